// File: rtl/l2_bank_resp_gen.sv
// l2_bank_resp_gen: per-bank response generator for the L2 crossbar.
// Optional output register stage: define L2_RESP_OUT_REG_EN.
module l2_bank_resp_gen #(
  parameter int N_MASTER    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  gnt_i,
  input  logic                  wen_i,
  input  logic [N_MASTER-1:0]   id_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [N_MASTER-1:0]   r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  busy_o,
  output logic                  id_err_o
);

`ifdef L2_RESP_OUT_REG_EN
  localparam int OutStg = 1;
`else
  localparam int OutStg = 0;
`endif
  localparam int CntMax = MEM_LATENCY + OutStg;
  localparam int CW     = $clog2(CntMax + 1);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_lat
    $error("MEM_LATENCY must be in 1..4");
  end

  logic                  id_ok;
  logic                  acc;
  logic                  bad;
  logic                  emit;
  logic [MEM_LATENCY-1:0] st_v;
  logic [N_MASTER-1:0]   st_id [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] st_rd;
  logic                  tail_v;
  logic                  tail_rd;
  logic [N_MASTER-1:0]   tail_id;
  logic [N_MASTER-1:0]   resp_v;
  logic [DATA_WIDTH-1:0] resp_d;
  logic [CW-1:0]         count;

  assign id_ok = $onehot(id_i);
  assign acc   = req_i & gnt_i & id_ok;
  assign bad   = req_i & gnt_i & ~id_ok;

  // Tracking pipeline: stage 0 captures the accept, later stages shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_v <= '0;
    end else begin
      st_v[0]  <= acc;
      st_id[0] <= id_i;
      st_rd[0] <= wen_i;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        st_v[i]  <= st_v[i-1];
        st_id[i] <= st_id[i-1];
        st_rd[i] <= st_rd[i-1];
      end
    end
  end

  assign tail_v  = st_v[MEM_LATENCY-1];
  assign tail_rd = st_rd[MEM_LATENCY-1];
  assign tail_id = st_id[MEM_LATENCY-1];
  assign resp_v  = tail_v ? tail_id : '0;
  assign resp_d  = (tail_v & tail_rd) ? mem_rdata_i : '0;

`ifdef L2_RESP_OUT_REG_EN
  logic [N_MASTER-1:0]   r_valid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;

  // Output register: cuts the path from mem_rdata_i to the fan-in tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= '0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= resp_v;
      r_rdata_q <= resp_d;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_rdata_o = r_rdata_q;
  assign emit      = |r_valid_q;
`else
  assign r_valid_o = resp_v;
  assign r_rdata_o = resp_d;
  assign emit      = tail_v;
`endif

  // In-flight counter: accepts in, emitted responses out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (acc && !emit) begin
      count <= count + CW'(1);
    end else if (!acc && emit) begin
      count <= count - CW'(1);
    end
  end

  assign busy_o = (count != '0);

  // Sticky flag for requests accepted with a malformed ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_err_o <= 1'b0;
    end else if (bad) begin
      id_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_bank_resp_gen.sv
// tb_l2_bank_resp_gen: scoreboard bench, three DUTs at latency 1, 2, 3.
// Expected responses are queued at issue and popped by a monitor.
module tb_l2_bank_resp_gen;

`ifdef L2_RESP_OUT_REG_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  typedef struct {
    int          acc;
    int          due;
    logic [3:0]  id;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  idv;
  logic [63:0] mem_rdata;
  logic [3:0]  rv   [3];
  logic [63:0] rd   [3];
  logic        busy [3];
  logic        err  [3];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic err_exp = 1'b0;
  exp_t q [3][$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input int c);
    return {32'hDEAD_BEEF, 32'(c)};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    l2_bank_resp_gen #(
      .N_MASTER(4),
      .DATA_WIDTH(64),
      .MEM_LATENCY(k + 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .req_i(req),
      .gnt_i(gnt),
      .wen_i(wen),
      .id_i(idv),
      .mem_rdata_i(mem_rdata),
      .r_valid_o(rv[k]),
      .r_rdata_o(rd[k]),
      .busy_o(busy[k]),
      .id_err_o(err[k])
    );

    always @(negedge clk) begin
      if (mon_en) begin
        n_cmp++;
        if (int'(u_dut.count) > k + 1 + E) begin
          n_fail++;
          $display("FAIL cnt_bound lat%0d: count %0d exceeds %0d",
                   k + 1, u_dut.count, k + 1 + E);
        end
      end
    end
  end

  initial begin
    mem_rdata = pat(0);
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = pat(cyc);
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat%0d cyc%0d: got %h want %h",
               nm, k + 1, cyc, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    logic be;
    exp_t e;
    be = 1'b0;
    foreach (q[k][j]) if (q[k][j].acc < cyc) be = 1'b1;
    chk("busy", k, 64'(busy[k]), 64'(be));
    chk("id_err", k, 64'(err[k]), 64'(err_exp));
    while (q[k].size() > 0 && q[k][0].due < cyc) begin
      e = q[k].pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missed lat%0d cyc%0d: got none want id %b due %0d",
               k + 1, cyc, e.id, e.due);
    end
    if (rv[k] != 4'b0) begin
      if (q[k].size() == 0 || q[k][0].due != cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected lat%0d cyc%0d: got valid %b want none",
                 k + 1, cyc, rv[k]);
      end else begin
        e = q[k].pop_front();
        chk("r_valid", k, 64'(rv[k]), 64'(e.id));
        chk("r_rdata", k, rd[k], e.data);
      end
    end else begin
      if (q[k].size() > 0 && q[k][0].due == cyc) begin
        e = q[k].pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL no_resp lat%0d cyc%0d: got valid 0 want %b",
                 k + 1, cyc, e.id);
      end
      chk("rdata_idle", k, rd[k], 64'h0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en)
        for (int k = 0; k < 3; k++) check_inst(k);
    end
  end

  task automatic tick(input logic r, input logic g,
                      input logic w, input logic [3:0] id);
    logic was_rst;
    logic bad;
    exp_t e;
    req = r;
    gnt = g;
    wen = w;
    idv = id;
    was_rst = rst;
    bad = r && g && !$onehot(id);
    if (r && g && !rst && $onehot(id)) begin
      for (int k = 0; k < 3; k++) begin
        e.acc  = cyc;
        e.due  = cyc + k + 1 + E;
        e.id   = id;
        e.data = w ? pat(cyc + k + 1) : 64'h0;
        q[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
      err_exp = 1'b0;
    end else if (bad) begin
      err_exp = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'b0);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    gnt = 1'b0;
    wen = 1'b0;
    idv = 4'b0;
    tick(1'b0, 1'b0, 1'b0, 4'b0);
    mon_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 4'b0);
    rst = 1'b0;
    idle(2);
    tick(1'b1, 1'b1, 1'b1, 4'b0100);
    idle(6);
    tick(1'b1, 1'b1, 1'b1, 4'b0001);
    tick(1'b1, 1'b1, 1'b1, 4'b0010);
    tick(1'b1, 1'b1, 1'b1, 4'b0100);
    tick(1'b1, 1'b1, 1'b1, 4'b1000);
    idle(7);
    tick(1'b1, 1'b1, 1'b0, 4'b0010);
    idle(6);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, 4'b0001);
    idle(2);
    tick(1'b1, 1'b1, 1'b1, 4'b0110);
    idle(3);
    tick(1'b1, 1'b1, 1'b1, 4'b0000);
    idle(3);
    tick(1'b1, 1'b1, 1'b1, 4'b1000);
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 4'b0001);
    rst = 1'b0;
    idle(6);
    tick(1'b1, 1'b1, 1'b0, 4'b1000);
    tick(1'b1, 1'b1, 1'b1, 4'b0001);
    tick(1'b1, 1'b0, 1'b1, 4'b0010);
    tick(1'b1, 1'b1, 1'b1, 4'b0100);
    idle(8);
    for (int k = 0; k < 3; k++)
      chk("drain", k, 64'(q[k].size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
